// File: rtl/dco_pkg.sv
// +----------------------------------------------------------------------------+
// | dco_pkg: shared constants, FSM state type and code-width helper            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package dco_pkg;

  localparam int unsigned c_DEF_ROWS       = 16;
  localparam int unsigned c_DEF_COLS       = 16;
  localparam int unsigned c_DEF_STEP       = 4;
  localparam int unsigned c_DEF_RESET_CODE = 128;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SLEW = 1'b1
  } state_e;

  function automatic int unsigned code_width(input int unsigned rows, input int unsigned cols);
    return $clog2(rows * cols);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dco_bank_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | dco_bank_ctrl_if: target handshake plus decoded bank-control outputs       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface dco_bank_ctrl_if
  import dco_pkg::*;
#(
  parameter int unsigned ROWS = c_DEF_ROWS,
  parameter int unsigned COLS = c_DEF_COLS
);

  localparam int unsigned N = code_width(ROWS, COLS);

  logic [N-1:0]    tune_word;
  logic            tune_valid;
  logic            tune_ready;
  logic [N-1:0]    code;
  logic [ROWS-1:0] row_all;
  logic [ROWS-1:0] row;
  logic [COLS-1:0] col;
  logic            busy;
  logic            settled;

  modport master (
    output tune_word, tune_valid,
    input  tune_ready, code, row_all, row, col, busy, settled
  );

  modport slave (
    input  tune_word, tune_valid,
    output tune_ready, code, row_all, row, col, busy, settled
  );

endinterface

`default_nettype wire

// File: rtl/dco_bank_dec.sv
// +----------------------------------------------------------------------------+
// | dco_bank_dec: code -> row_all / one-hot row / column thermometer           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module dco_bank_dec
  import dco_pkg::*;
#(
  parameter  int unsigned ROWS = c_DEF_ROWS,
  parameter  int unsigned COLS = c_DEF_COLS,
  localparam int unsigned N    = code_width(ROWS, COLS)
) (
  input  wire logic [N-1:0]    code_i,
  output logic      [ROWS-1:0] row_all_o,
  output logic      [ROWS-1:0] row_o,
  output logic      [COLS-1:0] col_o
);

  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned RW = N - CW;

  // Power-of-2 geometry lets full/part be plain bit fields of the code.
  logic [RW-1:0] w_full;
  logic [CW-1:0] w_part;

  assign w_full = code_i[N-1:CW];
  assign w_part = code_i[CW-1:0];

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    localparam logic [RW-1:0] c_IDX = RW'(i);
    assign row_all_o[i] = (c_IDX < w_full);
    assign row_o[i]     = (c_IDX == w_full);
  end

  for (genvar j = 0; j < COLS; j++) begin : g_col
    localparam logic [CW-1:0] c_JDX = CW'(j);
    assign col_o[j] = (c_JDX < w_part);
  end

endmodule

`default_nettype wire

// File: rtl/dco_bank_ctrl.sv
// +----------------------------------------------------------------------------+
// | dco_bank_ctrl: slew-limited DCO bank tuning with registered decode outputs |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module dco_bank_ctrl
  import dco_pkg::*;
#(
  parameter  int unsigned ROWS       = c_DEF_ROWS,
  parameter  int unsigned COLS       = c_DEF_COLS,
  parameter  int unsigned STEP       = c_DEF_STEP,
  parameter  int unsigned RESET_CODE = c_DEF_RESET_CODE,
  localparam int unsigned N          = code_width(ROWS, COLS)
) (
  input wire logic        clk,
  input wire logic        rst,
  dco_bank_ctrl_if.slave  tune_io
);

  localparam logic [N-1:0] c_RESET  = N'(RESET_CODE);
  localparam logic [N:0]   c_STEP_W = (N+1)'(STEP);
  localparam logic [N-1:0] c_STEP_N = N'(STEP);

  state_e          state_q;
  logic [N-1:0]    code_q;
  logic [N-1:0]    target_q;
  logic            ready_q;
  logic            busy_q;
  logic            settled_q;
  logic [ROWS-1:0] row_all_q;
  logic [ROWS-1:0] row_q;
  logic [COLS-1:0] col_q;

  logic signed [N:0] w_diff;
  logic [N:0]        w_mag;
  logic [N-1:0]      w_step;
  logic [N-1:0]      code_d;
  logic [ROWS-1:0]   w_row_all;
  logic [ROWS-1:0]   w_row;
  logic [COLS-1:0]   w_col;

  // Step is clamped to the remaining distance, so the code can neither overshoot nor wrap.
  always_comb begin
    w_diff = $signed({1'b0, target_q}) - $signed({1'b0, code_q});
    w_mag  = w_diff[N] ? $unsigned(-w_diff) : $unsigned(w_diff);
    w_step = (w_mag > c_STEP_W) ? c_STEP_N : w_mag[N-1:0];
    code_d = code_q;
    if (rst) begin
      code_d = c_RESET;
    end else if (state_q == SLEW) begin
      code_d = w_diff[N] ? (code_q - w_step) : (code_q + w_step);
    end
  end

  dco_bank_dec #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_dec (
    .code_i    (code_d),
    .row_all_o (w_row_all),
    .row_o     (w_row),
    .col_o     (w_col)
  );

  always_ff @(posedge clk) begin
    // Decoded vectors load from the next-code value so they never lag code.
    row_all_q <= w_row_all;
    row_q     <= w_row;
    col_q     <= w_col;
    code_q    <= code_d;
    if (rst) begin
      state_q   <= IDLE;
      target_q  <= c_RESET;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      settled_q <= 1'b0;
    end else begin
      settled_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (tune_io.tune_valid) begin
            target_q <= tune_io.tune_word;
            if (tune_io.tune_word == code_q) begin
              settled_q <= 1'b1;
            end else begin
              state_q <= SLEW;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end
        SLEW: begin
          if (code_d == target_q) begin
            state_q   <= IDLE;
            settled_q <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tune_io.tune_ready = ready_q;
  assign tune_io.code       = code_q;
  assign tune_io.row_all    = row_all_q;
  assign tune_io.row        = row_q;
  assign tune_io.col        = col_q;
  assign tune_io.busy       = busy_q;
  assign tune_io.settled    = settled_q;

endmodule

`default_nettype wire

// File: tb/tb_dco_bank_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_dco_bank_ctrl: vector table, random targets and a STEP=1 decode sweep   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dco_bank_ctrl;

  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int STEP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m0;
  int   m1;

  always #5 clk = ~clk;

  dco_bank_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) if0 ();
  dco_bank_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) if1 ();

  dco_bank_ctrl #(.ROWS(ROWS), .COLS(COLS), .STEP(STEP), .RESET_CODE(128)) dut0 (
    .clk     (clk),
    .rst     (rst),
    .tune_io (if0)
  );

  dco_bank_ctrl #(.ROWS(ROWS), .COLS(COLS), .STEP(1), .RESET_CODE(0)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .tune_io (if1)
  );

  typedef struct {
    logic [7:0] word;
    int         lat;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected decode from code arithmetic plus a cell-by-cell enable count.
  task automatic chk_dec(input string tag, input int m, input logic [15:0] ra,
                         input logic [15:0] r, input logic [15:0] c);
    int cnt;
    cnt = 0;
    chk({tag, " row_all"}, {16'd0, ra}, (32'd1 << (m / COLS)) - 32'd1);
    chk({tag, " row"},     {16'd0, r},  32'd1 << (m / COLS));
    chk({tag, " col"},     {16'd0, c},  (32'd1 << (m % COLS)) - 32'd1);
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        cnt += int'(ra[i] | (r[i] & c[j]));
    chk({tag, " cells"}, cnt, m);
  endtask

  function automatic int model_step(input int m, input int tgt, input int step);
    int d;
    d = tgt - m;
    if (d > step)       return m + step;
    else if (d < -step) return m - step;
    else                return tgt;
  endfunction

  task automatic apply(input logic [7:0] w, input int exp_lat, input string tag);
    int n;
    chk({tag, " ready_pre"}, if0.tune_ready, 1);
    if0.tune_word  = w;
    if0.tune_valid = 1'b1;
    tick();
    if0.tune_valid = 1'b0;
    chk({tag, " busy_acc"}, if0.busy, (int'(w) != m0) ? 1 : 0);
    n = 0;
    while (!if0.settled && n < 400) begin
      chk({tag, " ready_slew"}, if0.tune_ready, 0);
      tick();
      n++;
      m0 = model_step(m0, int'(w), STEP);
      chk({tag, " code"}, if0.code, m0);
      chk_dec(tag, m0, if0.row_all, if0.row, if0.col);
    end
    chk({tag, " latency"}, n, exp_lat);
    chk({tag, " code_final"}, if0.code, w);
    chk({tag, " ready_done"}, if0.tune_ready, 1);
    chk({tag, " busy_done"}, if0.busy, 0);
    tick();
    chk({tag, " settled_pulse"}, if0.settled, 0);
  endtask

  initial begin
    int n;
    logic [7:0] w;

    vecs[0] = '{8'd140, 3};
    vecs[1] = '{8'd140, 0};
    vecs[2] = '{8'd3,   35};
    vecs[3] = '{8'd0,   1};
    vecs[4] = '{8'd0,   0};
    vecs[5] = '{8'd255, 64};
    vecs[6] = '{8'd254, 1};
    vecs[7] = '{8'd255, 1};
    vecs[8] = '{8'd128, 32};

    if0.tune_word = '0; if0.tune_valid = 1'b0;
    if1.tune_word = '0; if1.tune_valid = 1'b0;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst code", if0.code, 128);
    chk_dec("rst", 128, if0.row_all, if0.row, if0.col);
    chk("rst ready", if0.tune_ready, 1);
    chk("rst busy", if0.busy, 0);
    chk("rst settled", if0.settled, 0);
    chk("rst1 code", if1.code, 0);
    chk_dec("rst1", 0, if1.row_all, if1.row, if1.col);
    rst = 1'b0;
    tick();
    m0 = 128;

    for (int k = 0; k < 9; k++)
      apply(vecs[k].word, vecs[k].lat, $sformatf("vec%0d", k));

    // Target 200 accepted, then 255 held on the bus during the slew.
    if0.tune_word = 8'd200; if0.tune_valid = 1'b1;
    tick();
    if0.tune_word = 8'd255;
    n = 0;
    while (!if0.settled && n < 400) begin
      tick();
      n++;
      m0 = model_step(m0, 200, STEP);
      chk("hold code", if0.code, m0);
    end
    chk("hold latency", n, 18);
    chk("hold final", if0.code, 200);
    chk("hold ready", if0.tune_ready, 1);
    tick();
    chk("b2b busy", if0.busy, 1);
    chk("b2b code", if0.code, 200);
    tick();
    chk("b2b step1", if0.code, 204);
    tick();
    chk("b2b step2", if0.code, 208);
    if0.tune_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid rst code", if0.code, 128);
    chk("mid rst busy", if0.busy, 0);
    chk("mid rst ready", if0.tune_ready, 1);
    chk("mid rst settled", if0.settled, 0);
    chk_dec("mid rst", 128, if0.row_all, if0.row, if0.col);
    rst = 1'b0;
    tick();
    chk("post rst code", if0.code, 128);
    chk("post rst busy", if0.busy, 0);
    m0 = 128;

    for (int k = 0; k < 20; k++) begin
      w = 8'($urandom_range(0, 255));
      n = (int'(w) > m0) ? int'(w) - m0 : m0 - int'(w);
      apply(w, (n + STEP - 1) / STEP, $sformatf("rnd%0d", k));
    end

    // STEP=1 instance walks every code 0..255.
    m1 = 0;
    if1.tune_word = 8'd255; if1.tune_valid = 1'b1;
    tick();
    if1.tune_valid = 1'b0;
    n = 0;
    while (!if1.settled && n < 300) begin
      tick();
      n++;
      m1 = model_step(m1, 255, 1);
      chk("sweep code", if1.code, m1);
      chk("sweep onehot", $countones(if1.row), 1);
      chk_dec("sweep", m1, if1.row_all, if1.row, if1.col);
    end
    chk("sweep latency", n, 255);
    chk("sweep top row_all", if1.row_all, 16'h7FFF);
    chk("sweep top col", if1.col, 16'h7FFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
